sram_burst_controller: RTL

//  Parametrised async-SRAM controller: single-beat or burst read/write with programmable wait states.

---
 rtl/sram_burst_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sram_burst_controller.sv
// Async-SRAM controller: single-beat or burst read/write with programmable wait states.
// Optional SRAM_RR_ARB_EN: round-robin between simultaneous read/write requests (default: write wins).
module sram_burst_controller #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH  = 19,
   parameter int unsigned BURST_WIDTH = 4,
   parameter int unsigned READ_WAIT   = 2,
   parameter int unsigned WRITE_WAIT  = 1
) (
   input  logic                   iClk,
   input  logic                   notReset,
   input  logic [ADDR_WIDTH-1:0]  iAddr,
   input  logic [BURST_WIDTH-1:0] iBurstLen,
   input  logic                   iReadRequest,
   input  logic                   iWriteRequest,
   input  logic [DATA_WIDTH-1:0]  iData,
   output logic                   oReadGranted,
   output logic                   oWriteGranted,
   output logic                   oWriteDataAck,
   output logic [DATA_WIDTH-1:0]  oData,
   output logic                   oReadDataValid,
   output logic                   oDataWritten,
   output logic                   oBusy,
   output logic [ADDR_WIDTH-1:0]  sr_A,
   inout  wire  [DATA_WIDTH-1:0]  sr_D,
   output logic                   sr_CE_NOT,
   output logic                   sr_OE_NOT,
   output logic                   sr_WE_NOT
);

   localparam int unsigned WAIT_MAX = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE, RD_SETUP, RD_WAIT, RD_CAPTURE, WR_SETUP, WR_PULSE, WR_HOLD, TURNAROUND
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [BURST_WIDTH-1:0] rem_q, rem_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rd_acc, wr_acc, pick_wr;

   logic [DATA_WIDTH-1:0]  wdata_q;
   logic                   dq_oe_q, rd_cap_q;
   logic                   ce_q, oe_q, we_q, valid_q, written_q, ack_q, busy_q;
   logic                   rgrant_q, wgrant_q;
   logic [ADDR_WIDTH-1:0]  sra_q;
   logic [DATA_WIDTH-1:0]  odata_q;

`ifdef SRAM_RR_ARB_EN
   logic prio_rd_q, prio_rd_d;
   assign pick_wr = iWriteRequest & ~(iReadRequest & prio_rd_q);
`else
   assign pick_wr = iWriteRequest;
`endif

   // Next-state: beat sequencing, wait-state counting, burst address/count update
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      rd_acc  = 1'b0;
      wr_acc  = 1'b0;
`ifdef SRAM_RR_ARB_EN
      prio_rd_d = prio_rd_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (iWriteRequest || iReadRequest) begin
               addr_d = iAddr;
               rem_d  = (iBurstLen == '0) ? BURST_WIDTH'(1) : iBurstLen;
               if (pick_wr) begin
                  wr_acc  = 1'b1;
                  state_d = WR_SETUP;
               end else begin
                  rd_acc  = 1'b1;
                  state_d = RD_SETUP;
               end
`ifdef SRAM_RR_ARB_EN
               if (iWriteRequest && iReadRequest) prio_rd_d = pick_wr;
`endif
            end
         end
         RD_SETUP: begin
            cnt_d   = CNT_W'(1);
            state_d = (READ_WAIT > 1) ? RD_WAIT : RD_CAPTURE;
         end
         RD_WAIT: begin
            if (cnt_q >= CNT_W'(READ_WAIT - 1)) state_d = RD_CAPTURE;
            else                                cnt_d   = cnt_q + CNT_W'(1);
         end
         RD_CAPTURE: begin
            if (rem_q > BURST_WIDTH'(1)) begin
               rem_d   = rem_q - BURST_WIDTH'(1);
               addr_d  = addr_q + ADDR_WIDTH'(1);
               state_d = RD_SETUP;
            end else begin
               state_d = TURNAROUND;
            end
         end
         WR_SETUP: begin
            cnt_d   = CNT_W'(1);
            state_d = WR_PULSE;
         end
         WR_PULSE: begin
            if (cnt_q >= CNT_W'(WRITE_WAIT)) state_d = WR_HOLD;
            else                             cnt_d   = cnt_q + CNT_W'(1);
         end
         WR_HOLD: begin
            if (rem_q > BURST_WIDTH'(1)) begin
               rem_d   = rem_q - BURST_WIDTH'(1);
               addr_d  = addr_q + ADDR_WIDTH'(1);
               state_d = WR_SETUP;
            end else begin
               state_d = TURNAROUND;
            end
         end
         TURNAROUND: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge notReset) begin
      if (!notReset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
`ifdef SRAM_RR_ARB_EN
         prio_rd_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
`ifdef SRAM_RR_ARB_EN
         prio_rd_q <= prio_rd_d;
`endif
      end
   end

   // Pin and handshake register: SRAM pins follow the state one cycle later
   always_ff @(posedge iClk or negedge notReset) begin
      if (!notReset) begin
         ce_q      <= 1'b1;
         oe_q      <= 1'b1;
         we_q      <= 1'b1;
         dq_oe_q   <= 1'b0;
         sra_q     <= '0;
         rd_cap_q  <= 1'b0;
         valid_q   <= 1'b0;
         odata_q   <= '0;
         written_q <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         rgrant_q  <= 1'b0;
         wgrant_q  <= 1'b0;
         wdata_q   <= '0;
      end else begin
         ce_q      <= (state_q == IDLE) || (state_q == TURNAROUND);
         oe_q      <= !(state_q inside {RD_SETUP, RD_WAIT, RD_CAPTURE});
         we_q      <= (state_q != WR_PULSE);
         dq_oe_q   <= state_q inside {WR_SETUP, WR_PULSE, WR_HOLD};
         sra_q     <= addr_q;
         rd_cap_q  <= (state_q == RD_CAPTURE);
         valid_q   <= rd_cap_q;
         if (rd_cap_q) odata_q <= sr_D;
         written_q <= (state_q == WR_HOLD);
         ack_q     <= (state_q == WR_HOLD) && (rem_q > BURST_WIDTH'(1));
         busy_q    <= (state_d != IDLE);
         rgrant_q  <= rd_acc;
         wgrant_q  <= wr_acc;
         // Master holds each beat until the end of its grant/ack cycle
         if (wgrant_q || ack_q) wdata_q <= iData;
      end
   end

   assign sr_D           = dq_oe_q ? wdata_q : {DATA_WIDTH{1'bz}};
   assign sr_A           = sra_q;
   assign sr_CE_NOT      = ce_q;
   assign sr_OE_NOT      = oe_q;
   assign sr_WE_NOT      = we_q;
   assign oData          = odata_q;
   assign oReadDataValid = valid_q;
   assign oDataWritten   = written_q;
   assign oWriteDataAck  = ack_q;
   assign oBusy          = busy_q;
   assign oReadGranted   = rgrant_q;
   assign oWriteGranted  = wgrant_q;

endmodule
